// File: rtl/piano_pkg.sv
// piano_pkg: shared types and constants for the note scheduler and its key encoder.
package piano_pkg;

    // Sequencer states:
    // state     | meaning
    // ST_IDLE   | silent, waiting for a key or auto enable
    // ST_MANUAL | a key is held, output follows keys and octave switches
    // ST_FETCH  | song ROM address presented
    // ST_WAIT   | ROM word returned, captured at the end of this cycle
    // ST_PLAY   | captured note sounding, beat counter running
    // ST_GAP    | silence between auto notes
    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_MANUAL = 3'd1,
        ST_FETCH  = 3'd2,
        ST_WAIT   = 3'd3,
        ST_PLAY   = 3'd4,
        ST_GAP    = 3'd5
    } state_e;

    localparam logic [1:0] OCT_LOW  = 2'd0;
    localparam logic [1:0] OCT_MID  = 2'd1;
    localparam logic [1:0] OCT_HIGH = 2'd2;

    // Song ROM word layout: [7:6] octave, [5:3] note, [2:0] beats
    localparam int OCT_MSB   = 7;
    localparam int OCT_LSB   = 6;
    localparam int NOTE_MSB  = 5;
    localparam int NOTE_LSB  = 3;
    localparam int BEATS_MSB = 2;
    localparam int BEATS_LSB = 0;

    localparam logic [2:0] END_MARK = 3'd0;

endpackage

// File: rtl/key_encoder.sv
// key_encoder: 7-key priority encoder (btn[6] highest = do) and switch-to-octave map.
module key_encoder
    import piano_pkg::*;
(
    input  logic [6:0] btn,
    input  logic [1:0] sw,
    output logic       key_any,
    output logic [2:0] key_idx,
    output logic [1:0] key_oct
);

    // Ascending scan so the highest set key is the last to write key_idx.
    always_comb begin
        key_any = |btn;
        key_idx = 3'd0;
        for (int i = 0; i < 7; i++) begin
            if (btn[i]) key_idx = 3'(7 - i);
        end
    end

    // Both 10 and 01 select the middle octave.
    always_comb begin
        unique case (sw)
            2'b11:   key_oct = OCT_HIGH;
            2'b00:   key_oct = OCT_LOW;
            default: key_oct = OCT_MID;
        endcase
    end

endmodule

// File: rtl/note_scheduler.sv
// note_scheduler: arbitrates manual keys and ROM-driven auto-play into one
// registered note stream; manual play pauses the song, which resumes in place.
module note_scheduler
    import piano_pkg::*;
#(
    parameter int BEAT_CYCLES = 12500000,
    parameter int GAP_CYCLES  = 1250000,
    parameter int ADDR_W      = 6
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              auto,
    input  logic [1:0]        sw,
    input  logic [6:0]        btn,
    output logic [ADDR_W-1:0] rom_addr,
    input  logic [7:0]        rom_data,
    output logic              note_valid,
    output logic [1:0]        note_oct,
    output logic [2:0]        note_idx,
    output logic              auto_active,
    output logic [ADDR_W-1:0] song_pos
);

    localparam int BEAT_W = $clog2(7 * BEAT_CYCLES + 1);
    localparam int GAP_W  = $clog2(GAP_CYCLES + 1);

    logic [9:0] sync1_q, sync2_q;
    logic       auto_s;
    logic [1:0] sw_s;
    logic [6:0] btn_s;
    logic       key_any;
    logic [2:0] key_idx;
    logic [1:0] key_oct;

    state_e              state_q, state_d, resume_q, resume_d;
    logic                paused_q, paused_d;
    logic [ADDR_W-1:0]   rom_addr_q, rom_addr_d, song_pos_q, song_pos_d;
    logic [BEAT_W-1:0]   beat_cnt_q, beat_cnt_d;
    logic [GAP_W-1:0]    gap_cnt_q, gap_cnt_d;
    logic [7:0]          word_q, word_d;
    logic                note_valid_q, note_valid_d, auto_active_q, auto_active_d;
    logic [1:0]          note_oct_q, note_oct_d;
    logic [2:0]          note_idx_q, note_idx_d;

    // Two-flop synchronizer for all asynchronous user inputs.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sync1_q <= '0;
            sync2_q <= '0;
        end else begin
            sync1_q <= {auto, sw, btn};
            sync2_q <= sync1_q;
        end
    end

    assign auto_s = sync2_q[9];
    assign sw_s   = sync2_q[8:7];
    assign btn_s  = sync2_q[6:0];

    key_encoder u_key_encoder (
        .btn     (btn_s),
        .sw      (sw_s),
        .key_any (key_any),
        .key_idx (key_idx),
        .key_oct (key_oct)
    );

    // Next-state, counters and output values; outputs are derived from the next
    // state so they appear on the same edge as the transition.
    always_comb begin
        state_d    = state_q;
        resume_d   = resume_q;
        paused_d   = paused_q;
        rom_addr_d = rom_addr_q;
        song_pos_d = song_pos_q;
        beat_cnt_d = beat_cnt_q;
        gap_cnt_d  = gap_cnt_q;
        word_d     = word_q;
        unique case (state_q)
            ST_IDLE: begin
                if (key_any)     state_d = ST_MANUAL;
                else if (auto_s) state_d = ST_FETCH;
            end
            ST_MANUAL: begin
                if (!auto_s && paused_q) begin
                    paused_d   = 1'b0;
                    rom_addr_d = '0;
                    song_pos_d = '0;
                end
                if (!key_any) begin
                    if (auto_s && paused_q) begin
                        state_d  = resume_q;
                        paused_d = 1'b0;
                    end else if (auto_s) begin
                        state_d = ST_FETCH;
                    end else begin
                        state_d = ST_IDLE;
                    end
                end
            end
            default: begin
                if (!auto_s) begin
                    // Auto stop clears the song even when a key wins this cycle.
                    rom_addr_d = '0;
                    song_pos_d = '0;
                    paused_d   = 1'b0;
                    state_d    = key_any ? ST_MANUAL : ST_IDLE;
                end else if (key_any) begin
                    // A pause in FETCH/WAIT refetches the same address on resume.
                    state_d  = ST_MANUAL;
                    paused_d = 1'b1;
                    resume_d = (state_q == ST_PLAY || state_q == ST_GAP) ? state_q : ST_FETCH;
                end else begin
                    case (state_q)
                        ST_FETCH: state_d = ST_WAIT;
                        ST_WAIT: begin
                            word_d = rom_data;
                            if (rom_data[BEATS_MSB:BEATS_LSB] == END_MARK) begin
                                rom_addr_d = '0;
                                state_d    = ST_FETCH;
                            end else begin
                                beat_cnt_d = BEAT_W'(rom_data[BEATS_MSB:BEATS_LSB]) * BEAT_W'(BEAT_CYCLES);
                                song_pos_d = rom_addr_q;
                                state_d    = ST_PLAY;
                            end
                        end
                        ST_PLAY: begin
                            if (beat_cnt_q <= BEAT_W'(1)) begin
                                gap_cnt_d = GAP_W'(GAP_CYCLES);
                                state_d   = ST_GAP;
                            end else begin
                                beat_cnt_d = beat_cnt_q - 1'b1;
                            end
                        end
                        ST_GAP: begin
                            if (gap_cnt_q <= GAP_W'(1)) begin
                                rom_addr_d = rom_addr_q + 1'b1;
                                state_d    = ST_FETCH;
                            end else begin
                                gap_cnt_d = gap_cnt_q - 1'b1;
                            end
                        end
                        default: ;
                    endcase
                end
            end
        endcase

        note_valid_d = 1'b0;
        note_oct_d   = OCT_LOW;
        note_idx_d   = 3'd0;
        if (state_d == ST_MANUAL) begin
            note_valid_d = 1'b1;
            note_oct_d   = key_oct;
            note_idx_d   = key_idx;
        end else if (state_d == ST_PLAY && word_d[NOTE_MSB:NOTE_LSB] != 3'd0) begin
            note_valid_d = 1'b1;
            note_oct_d   = word_d[OCT_MSB:OCT_LSB];
            note_idx_d   = word_d[NOTE_MSB:NOTE_LSB];
        end
        auto_active_d = (state_d == ST_FETCH) || (state_d == ST_WAIT) ||
                        (state_d == ST_PLAY)  || (state_d == ST_GAP);
    end

    // Sequencer state, counters and registered outputs.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q       <= ST_IDLE;
            resume_q      <= ST_FETCH;
            paused_q      <= 1'b0;
            rom_addr_q    <= '0;
            song_pos_q    <= '0;
            beat_cnt_q    <= '0;
            gap_cnt_q     <= '0;
            word_q        <= '0;
            note_valid_q  <= 1'b0;
            note_oct_q    <= '0;
            note_idx_q    <= '0;
            auto_active_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            resume_q      <= resume_d;
            paused_q      <= paused_d;
            rom_addr_q    <= rom_addr_d;
            song_pos_q    <= song_pos_d;
            beat_cnt_q    <= beat_cnt_d;
            gap_cnt_q     <= gap_cnt_d;
            word_q        <= word_d;
            note_valid_q  <= note_valid_d;
            note_oct_q    <= note_oct_d;
            note_idx_q    <= note_idx_d;
            auto_active_q <= auto_active_d;
        end
    end

    assign rom_addr    = rom_addr_q;
    assign song_pos    = song_pos_q;
    assign note_valid  = note_valid_q;
    assign note_oct    = note_oct_q;
    assign note_idx    = note_idx_q;
    assign auto_active = auto_active_q;

endmodule

// File: tb/tb_note_scheduler.sv
// tb_note_scheduler: scenario tasks against a timeline model of the song and a
// priority/octave model of the keys.
module tb_note_scheduler;

    localparam int BEAT = 8;
    localparam int GAP  = 2;
    localparam int AW   = 6;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          auto_in = 1'b0;
    logic [1:0]    sw = 2'b00;
    logic [6:0]    btn = 7'b0;
    logic [AW-1:0] rom_addr, song_pos;
    logic [7:0]    rom_data = 8'h00;
    logic          note_valid, auto_active;
    logic [1:0]    note_oct;
    logic [2:0]    note_idx;
    logic [7:0]    rom [64];

    int errors = 0;
    int checks = 0;

    typedef struct packed {
        logic          v;
        logic [1:0]    o;
        logic [2:0]    i;
        logic [AW-1:0] p;
    } samp_t;

    samp_t exp_q[$];

    note_scheduler #(.BEAT_CYCLES(BEAT), .GAP_CYCLES(GAP), .ADDR_W(AW)) dut (
        .clk         (clk),
        .rst         (rst),
        .auto        (auto_in),
        .sw          (sw),
        .btn         (btn),
        .rom_addr    (rom_addr),
        .rom_data    (rom_data),
        .note_valid  (note_valid),
        .note_oct    (note_oct),
        .note_idx    (note_idx),
        .auto_active (auto_active),
        .song_pos    (song_pos)
    );

    always #5 clk = ~clk;

    // Synchronous song ROM: word valid one cycle after the address.
    always @(posedge clk) rom_data <= rom[rom_addr];

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic step(input int n);
        repeat (n) @(negedge clk);
    endtask

    function automatic logic [2:0] key_model(input logic [6:0] b);
        for (int k = 6; k >= 0; k--) if (b[k]) return 3'(7 - k);
        return 3'd0;
    endfunction

    function automatic logic [1:0] oct_model(input logic [1:0] s);
        if (s == 2'b11) return 2'd2;
        if (s == 2'b00) return 2'd0;
        return 2'd1;
    endfunction

    function automatic samp_t got_s();
        return {note_valid, note_oct, note_idx, song_pos};
    endfunction

    // One loop of the song from the first sounding cycle of entry 0: each note
    // sounds beats*BEAT cycles, then GAP silent cycles plus the two-cycle fetch of
    // the next word; the end marker costs one more fetch before address 0.
    function automatic void build_song();
        logic [AW-1:0] last;
        samp_t s;
        last = '0;
        exp_q.delete();
        for (int a = 0; a < 64; a++) begin
            if (rom[a][2:0] == 3'd0) begin
                s = '{1'b0, 2'd0, 3'd0, last};
                repeat (2) exp_q.push_back(s);
                break;
            end
            last = AW'(a);
            if (rom[a][5:3] != 3'd0) s = '{1'b1, rom[a][7:6], rom[a][5:3], last};
            else                     s = '{1'b0, 2'd0, 3'd0, last};
            repeat (int'(rom[a][2:0]) * BEAT) exp_q.push_back(s);
            s = '{1'b0, 2'd0, 3'd0, last};
            repeat (GAP + 2) exp_q.push_back(s);
        end
    endfunction

    task automatic test_reset();
        rst = 1'b0; auto_in = 1'b0; btn = '0; sw = '0;
        step(2);
        checks++;
        if ({note_valid, note_oct, note_idx, auto_active, song_pos, rom_addr} !== '0) begin
            errors++;
            $display("FAIL reset_outputs: got %b required all zero",
                     {note_valid, note_oct, note_idx, auto_active, song_pos, rom_addr});
        end
        rst = 1'b1;
        step(3);
        checks++;
        if ({note_valid, auto_active} !== 2'b00) begin
            errors++;
            $display("FAIL idle_after_reset: got valid=%b auto_active=%b required 0 0", note_valid, auto_active);
        end
    endtask

    task automatic test_manual_basic();
        sw = 2'b11; btn = 7'b1000000;
        step(2);
        checks++;
        if (note_valid !== 1'b0) begin
            errors++;
            $display("FAIL manual_early: got valid=%b required 0 two cycles after press", note_valid);
        end
        step(1);
        checks++;
        if ({note_valid, note_oct, note_idx} !== {1'b1, 2'd2, 3'd1}) begin
            errors++;
            $display("FAIL manual_on: got %b/%0d/%0d required 1/2/1", note_valid, note_oct, note_idx);
        end
        btn = '0;
        step(2);
        checks++;
        if (note_valid !== 1'b1) begin
            errors++;
            $display("FAIL release_early: got valid=%b required 1 two cycles after release", note_valid);
        end
        step(1);
        checks++;
        if ({note_valid, note_idx} !== 4'b0) begin
            errors++;
            $display("FAIL release_off: got valid=%b idx=%0d required 0 0", note_valid, note_idx);
        end
    endtask

    task automatic test_priority();
        logic [6:0] b;
        logic [1:0] s;
        sw = 2'b00; btn = 7'b0100001;
        step(3);
        checks++;
        if ({note_valid, note_oct, note_idx} !== {1'b1, 2'd0, 3'd2}) begin
            errors++;
            $display("FAIL priority_fixed: got %b/%0d/%0d required 1/0/2", note_valid, note_oct, note_idx);
        end
        sw = 2'b01;
        step(3);
        checks++;
        if ({note_valid, note_oct, note_idx} !== {1'b1, 2'd1, 3'd2}) begin
            errors++;
            $display("FAIL octave_01: got %b/%0d/%0d required 1/1/2", note_valid, note_oct, note_idx);
        end
        for (int n = 0; n < 12; n++) begin
            b = 7'($urandom_range(1, 127));
            s = 2'($urandom_range(0, 3));
            btn = b; sw = s;
            step(3);
            checks++;
            if ({note_valid, note_oct, note_idx} !== {1'b1, oct_model(s), key_model(b)}) begin
                errors++;
                $display("FAIL priority_rand btn=%b sw=%b: got %b/%0d/%0d required 1/%0d/%0d",
                         b, s, note_valid, note_oct, note_idx, oct_model(s), key_model(b));
            end
        end
        btn = '0;
        step(3);
        checks++;
        if (note_valid !== 1'b0) begin
            errors++;
            $display("FAIL priority_release: got valid=%b required 0", note_valid);
        end
    endtask

    task automatic test_song();
        samp_t e;
        foreach (rom[a]) rom[a] = 8'h00;
        rom[0] = {2'd1, 3'd1, 3'd2};
        rom[1] = {2'd2, 3'd0, 3'd1};
        rom[2] = {2'd2, 3'd3, 3'd1};
        build_song();
        auto_in = 1'b1;
        step(3);
        checks++;
        if ({auto_active, note_valid} !== 2'b10) begin
            errors++;
            $display("FAIL song_fetch: got auto_active=%b valid=%b required 1 0", auto_active, note_valid);
        end
        step(1);
        for (int j = 0; j < 2 * exp_q.size(); j++) begin
            sw = 2'($urandom);
            step(1);
            e = exp_q[j % exp_q.size()];
            checks++;
            if ({auto_active, got_s()} !== {1'b1, e}) begin
                errors++;
                $display("FAIL song_stream[%0d]: got aa=%b %h required aa=1 %h", j, auto_active, got_s(), e);
            end
        end
    endtask

    // Key pressed while the first note (16 cycles) plays; the sequencer sees it
    // two cycles after it is driven, with beat_cnt = 16 - seen = 10 left.
    task automatic test_pause();
        int press, seen, remain, k_end;
        samp_t e;
        logic ea;
        press  = 4;
        seen   = press + 2;
        remain = 2 * BEAT - seen;
        k_end  = seen + 20 + remain + GAP + 2;
        sw = 2'b10;
        for (int k = 0; k < k_end; k++) begin
            step(1);
            if (k <= seen) begin
                e = '{1'b1, 2'd1, 3'd1, 6'd0}; ea = 1'b1;
            end else if (k <= seen + 20) begin
                e = '{1'b1, 2'd1, 3'd7, 6'd0}; ea = 1'b0;
            end else if (k <= seen + 20 + remain) begin
                e = '{1'b1, 2'd1, 3'd1, 6'd0}; ea = 1'b1;
            end else begin
                e = '{1'b0, 2'd0, 3'd0, 6'd0}; ea = 1'b1;
            end
            checks++;
            if ({auto_active, got_s()} !== {ea, e}) begin
                errors++;
                $display("FAIL pause_resume[%0d]: got aa=%b %h required aa=%b %h", k, auto_active, got_s(), ea, e);
            end
            if (k == press)      btn = 7'b0000001;
            if (k == press + 20) btn = 7'b0000000;
        end
    endtask

    task automatic test_auto_drop();
        int n;
        samp_t e;
        n = 0;
        while (note_valid !== 1'b1 && n < 40) begin
            step(1);
            n++;
        end
        checks++;
        if (note_valid !== 1'b1) begin
            errors++;
            $display("FAIL wait_note: got valid=%b required 1 within 40 cycles", note_valid);
        end
        auto_in = 1'b0;
        step(2);
        checks++;
        if (note_valid !== 1'b1) begin
            errors++;
            $display("FAIL drop_early: got valid=%b required 1", note_valid);
        end
        step(1);
        checks++;
        if ({note_valid, auto_active, song_pos, rom_addr} !== '0) begin
            errors++;
            $display("FAIL drop_clear: got valid=%b aa=%b pos=%0d addr=%0d required all 0",
                     note_valid, auto_active, song_pos, rom_addr);
        end
        step(2);
        auto_in = 1'b1;
        step(4);
        for (int j = 0; j < 41; j++) begin
            step(1);
            e = exp_q[j];
            checks++;
            if ({auto_active, got_s()} !== {1'b1, e}) begin
                errors++;
                $display("FAIL restart_stream[%0d]: got aa=%b %h required aa=1 %h", j, auto_active, got_s(), e);
            end
        end
    endtask

    // Entered in the first GAP cycle after the third entry (song_pos 2).
    task automatic test_reset_mid();
        samp_t e;
        #2 rst = 1'b0;
        #1;
        checks++;
        if ({note_valid, note_oct, note_idx, auto_active, song_pos, rom_addr} !== '0) begin
            errors++;
            $display("FAIL async_reset: got %b required all zero",
                     {note_valid, note_oct, note_idx, auto_active, song_pos, rom_addr});
        end
        step(1);
        rst = 1'b1;
        step(4);
        checks++;
        if ({auto_active, note_valid, rom_addr} !== {1'b1, 1'b0, 6'd0}) begin
            errors++;
            $display("FAIL reset_refetch: got aa=%b valid=%b addr=%0d required 1 0 0", auto_active, note_valid, rom_addr);
        end
        for (int j = 0; j < 20; j++) begin
            step(1);
            e = exp_q[j];
            checks++;
            if ({auto_active, got_s()} !== {1'b1, e}) begin
                errors++;
                $display("FAIL post_reset_stream[%0d]: got aa=%b %h required aa=1 %h", j, auto_active, got_s(), e);
            end
        end
    endtask

    task automatic test_random_song();
        int n;
        samp_t e;
        auto_in = 1'b0;
        step(4);
        checks++;
        if ({auto_active, rom_addr, song_pos} !== '0) begin
            errors++;
            $display("FAIL stop_idle: got aa=%b addr=%0d pos=%0d required 0 0 0", auto_active, rom_addr, song_pos);
        end
        foreach (rom[a]) rom[a] = 8'h00;
        n = $urandom_range(2, 4);
        for (int a = 0; a < n; a++)
            rom[a] = {2'($urandom_range(0, 2)), 3'($urandom_range(0, 7)), 3'($urandom_range(1, 3))};
        build_song();
        auto_in = 1'b1;
        step(4);
        for (int j = 0; j < 2 * exp_q.size(); j++) begin
            step(1);
            e = exp_q[j % exp_q.size()];
            checks++;
            if ({auto_active, got_s()} !== {1'b1, e}) begin
                errors++;
                $display("FAIL rand_stream[%0d]: got aa=%b %h required aa=1 %h", j, auto_active, got_s(), e);
            end
        end
    endtask

    task automatic test_press_and_stop();
        step($urandom_range(5, 40));
        sw = 2'b11;
        btn = 7'b0000010;
        auto_in = 1'b0;
        step(3);
        checks++;
        if ({note_valid, note_oct, note_idx, auto_active, song_pos, rom_addr} !== {1'b1, 2'd2, 3'd6, 1'b0, 6'd0, 6'd0}) begin
            errors++;
            $display("FAIL press_stop: got v=%b o=%0d i=%0d aa=%b pos=%0d addr=%0d required 1 2 6 0 0 0",
                     note_valid, note_oct, note_idx, auto_active, song_pos, rom_addr);
        end
        btn = '0;
        step(3);
        checks++;
        if ({note_valid, auto_active, rom_addr} !== '0) begin
            errors++;
            $display("FAIL press_stop_release: got v=%b aa=%b addr=%0d required 0 0 0", note_valid, auto_active, rom_addr);
        end
        step(3);
        checks++;
        if (auto_active !== 1'b0) begin
            errors++;
            $display("FAIL press_stop_idle: got aa=%b required 0", auto_active);
        end
    endtask

    initial begin
        foreach (rom[a]) rom[a] = 8'h00;
        test_reset();
        test_manual_basic();
        test_priority();
        test_song();
        test_pause();
        test_auto_drop();
        test_reset_mid();
        test_random_song();
        test_press_and_stop();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
